// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - carry-segmented pipelined adder/subtractor with valid/ready flow control
// Operands are zero-padded to SEGMENTS*SEG_W bits so every slice has the same width.
module pipelined_addsub #(
  parameter int WIDTH    = 140,
  parameter int SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int SEG_W = (WIDTH + SEGMENTS - 1) / SEGMENTS;
  localparam int PW    = SEG_W * SEGMENTS;

  logic [PW-1:0]     a_q   [SEGMENTS+1];
  logic [PW-1:0]     b_q   [SEGMENTS+1];
  logic [PW-1:0]     s_q   [SEGMENTS+1];
  logic [SEGMENTS:0] c_q;
  logic [SEGMENTS:0] v_q;
  logic [SEG_W:0]    seg_sum [SEGMENTS];
  logic [WIDTH-1:0]  beff;
  logic              advance;

  assign beff     = sub ? ~b : b;
  assign advance  = out_ready | ~v_q[SEGMENTS];
  assign in_ready = advance;

  // Stage k+1 resolves slice k using the carry registered by stage k.
  always_comb begin
    for (int k = 0; k < SEGMENTS; k++) begin
      seg_sum[k] = {1'b0, a_q[k][k*SEG_W +: SEG_W]}
                 + {1'b0, b_q[k][k*SEG_W +: SEG_W]}
                 + {{SEG_W{1'b0}}, c_q[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SEGMENTS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= PW'(a);
        b_q[0] <= PW'(beff);
        c_q[0] <= sub | cin;
      end
      for (int k = 1; k <= SEGMENTS; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= seg_sum[k-1][SEG_W];
        s_q[k] <= s_q[k-1];
        s_q[k][(k-1)*SEG_W +: SEG_W] <= seg_sum[k-1][SEG_W-1:0];
      end
    end
  end

  // Padding bits above WIDTH are zero, so bit WIDTH of the padded sum is the true carry out.
  assign out_valid = v_q[SEGMENTS];
  assign sum       = (WIDTH+1)'({c_q[SEGMENTS], s_q[SEGMENTS]});
  assign ovf       = (a_q[SEGMENTS][WIDTH-1] == b_q[SEGMENTS][WIDTH-1]) &&
                     (s_q[SEGMENTS][WIDTH-1] != a_q[SEGMENTS][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub (W140/S4, W7/S3, W140/S1)
module tb_pipelined_addsub;

  localparam int W_OF [3] = '{140, 7, 140};
  localparam int S_OF [3] = '{4, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   in_valid, sub, cin, out_ready, lat_en;
  wire  [2:0]   in_ready, out_valid, ovf;
  logic [139:0] a [3];
  logic [139:0] b [3];
  wire  [140:0] sum0, sum2;
  wire  [7:0]   sum1;
  wire  [140:0] sum_x [3];

  assign sum_x[0] = sum0;
  assign sum_x[1] = {133'b0, sum1};
  assign sum_x[2] = sum2;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub #(.WIDTH(140), .SEGMENTS(4)) u_w140_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .sub(sub[0]), .cin(cin[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0), .ovf(ovf[0]));

  pipelined_addsub #(.WIDTH(7), .SEGMENTS(3)) u_w7_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][6:0]), .b(b[1][6:0]), .sub(sub[1]), .cin(cin[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1), .ovf(ovf[1]));

  pipelined_addsub #(.WIDTH(140), .SEGMENTS(1)) u_w140_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .sub(sub[2]), .cin(cin[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2), .ovf(ovf[2]));

  task automatic check(input string tag, input logic [141:0] got, input logic [141:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Golden (w+1)-bit result, returned as {ovf, sum}.
  function automatic logic [141:0] model(input int w, input logic [139:0] av, input logic [139:0] bv,
                                         input logic s, input logic c);
    logic [140:0] m, ae, be, r;
    logic o;
    m  = (141'(1) << w) - 141'(1);
    ae = {1'b0, av} & m;
    be = (s ? ~{1'b0, bv} : {1'b0, bv}) & m;
    r  = ae + be + 141'(s | c);
    r  = r & ((m << 1) | 141'(1));
    o  = (ae[w-1] == be[w-1]) && (r[w-1] != ae[w-1]);
    return {o, r};
  endfunction

  function automatic logic [139:0] rand140();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[139:0];
  endfunction

  function automatic logic [139:0] rnd_op(input int w);
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 140'(1) << (w - 1);
      3:       return (140'(1) << (w - 1)) - 140'(1);
      default: return rand140();
    endcase
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_mon
    logic [141:0] exp_q [$];
    int           t_q   [$];
    logic [141:0] held;
    logic [141:0] e;
    logic         holding = 1'b0;
    int           t;
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        t_q.delete();
        holding = 1'b0;
      end else begin
        if (holding) begin
          check("valid_held", 142'(out_valid[i]), 142'(1));
          check("sum_held", {ovf[i], sum_x[i]}, held);
        end
        if (out_valid[i] && out_ready[i]) begin
          check("beat_expected", 142'(exp_q.size() != 0), 142'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = t_q.pop_front();
            check("result", {ovf[i], sum_x[i]}, e);
            if (lat_en[i]) check("latency", 142'(cyc - t), 142'(S_OF[i] + 1));
          end
        end
        holding = out_valid[i] && !out_ready[i];
        held    = {ovf[i], sum_x[i]};
        if (in_valid[i] && in_ready[i]) begin
          exp_q.push_back(model(W_OF[i], a[i], b[i], sub[i], cin[i]));
          t_q.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input int i, input logic [139:0] av, input logic [139:0] bv,
                      input logic s, input logic c);
    bit acc = 1'b0;
    a[i] = av; b[i] = bv; sub[i] = s; cin[i] = c; in_valid[i] = 1'b1;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready[i];
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    check("accept", 142'(acc), 142'(1));
  endtask

  task automatic wait_out(input int i);
    bit seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid[i];
    end
    check("out_timeout", 142'(seen), 142'(1));
  endtask

  task automatic drain_all();
    bit empty = 1'b0;
    for (int k = 0; k < 500 && !empty; k++) begin
      @(negedge clk);
      empty = (g_mon[0].exp_q.size() + g_mon[1].exp_q.size() + g_mon[2].exp_q.size()) == 0;
    end
    check("drain", 142'(empty), 142'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int i);
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 2000; k++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          send(i, rnd_op(W_OF[i]), rnd_op(W_OF[i]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready[i] = ($urandom_range(0, 3) != 0);
        end
        out_ready[i] = 1'b1;
      end
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [139:0] x, y;
    rst_n = 1'b0; in_valid = '0; sub = '0; cin = '0; out_ready = '1; lat_en = '0;
    for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 142'(out_valid), 142'(0));
    check("rst_sum", 142'(sum0), 142'(0));
    check("rst_ovf", 142'(ovf), 142'(0));
    check("rst_in_ready", 142'(in_ready), 142'(3'b111));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beats with latency checking enabled.
    lat_en[0] = 1'b1;
    send(0, '1, '0, 1'b0, 1'b1);
    wait_out(0);
    check("t1_sum", 142'(sum0), 142'(1) << 140);
    check("t1_ovf", 142'(ovf[0]), 142'(0));
    @(posedge clk); #1;

    send(0, '0, 140'(1), 1'b1, 1'b0);
    wait_out(0);
    check("t2_sum", 142'(sum0), 142'({1'b0, {140{1'b1}}}));
    check("t2_ovf", 142'(ovf[0]), 142'(0));
    @(posedge clk); #1;

    send(0, {1'b0, {139{1'b1}}}, 140'(1), 1'b0, 1'b0);
    wait_out(0);
    check("t3_sum", 142'(sum0), 142'({2'b01, 139'b0}));
    check("t3_ovf", 142'(ovf[0]), 142'(1));
    @(posedge clk); #1;

    send(0, {1'b1, 139'b0}, 140'(1), 1'b1, 1'b0);
    wait_out(0);
    check("t3b_sum", 142'(sum0[139:0]), 142'({1'b0, {139{1'b1}}}));
    check("t3b_ovf", 142'(ovf[0]), 142'(1));
    @(posedge clk); #1;

    // Back-to-back stream with a 3-cycle downstream stall.
    lat_en[0] = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(0, rand140(), rand140(), k[0], k[1]);
      end
      begin
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin @(negedge clk); seen = out_valid[0]; end
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("t4_in_ready", 142'(in_ready[0]), 142'(0));
          check("t4_out_valid", 142'(out_valid[0]), 142'(1));
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
      end
    join
    drain_all();

    // Reset with beats in flight.
    for (int k = 0; k < 3; k++) send(0, rand140(), rand140(), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 142'(out_valid[0]), 142'(0));
    check("t5_sum", 142'(sum0), 142'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat_en[0] = 1'b1;
    x = rand140();
    y = rand140();
    send(0, x, y, 1'b0, 1'b1);
    wait_out(0);
    check("t5_first", {ovf[0], sum0}, model(140, x, y, 1'b0, 1'b1));
    @(posedge clk); #1;
    drain_all();
    lat_en[0] = 1'b0;

    // Random traffic on the narrow/odd and single-stage configurations.
    fork
      rand_run(1);
      rand_run(2);
    join
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
